// File: rtl/counter_wait_pkg.sv
// Shared types and default sizing for the counter_wait_sum block.
package counter_wait_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } chan_state_t;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefNch   = 2;

endpackage

// File: rtl/cw_channel.sv
// One counting channel: IDLE/RUN/HOLD FSM, wrapping counter and latched stop value.
module cw_channel
  import counter_wait_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             abort_i,
  input  logic             launch_i,
  input  logic             fire_i,
  input  logic             cont_i,
  input  logic [WIDTH-1:0] stop_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             hold_o,
  output logic             idle_o
);

  chan_state_t      state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] stop_q, stop_d;
  logic             at_stop;

  assign at_stop = (cnt_q == stop_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = StIdle;
    end else if (en_i) begin
      unique case (state_q)
        StIdle:  if (launch_i) state_d = StRun;
        StRun:   if (at_stop) state_d = StHold;
        StHold:  if (fire_i) state_d = cont_i ? StRun : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Counter and stop latch advance only on enabled, non-aborted cycles.
  always_comb begin
    cnt_d  = cnt_q;
    stop_d = stop_q;
    if (!abort_i && en_i) begin
      unique case (state_q)
        StIdle: begin
          if (launch_i) begin
            cnt_d  = '0;
            stop_d = stop_i;
          end
        end
        StRun:   if (!at_stop) cnt_d = cnt_q + WIDTH'(1);
        StHold:  if (fire_i && cont_i) cnt_d = cnt_q + WIDTH'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      stop_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      stop_q <= stop_d;
    end
  end

  always_comb begin
    cnt_o  = cnt_q;
    hold_o = (state_q == StHold);
    idle_o = (state_q == StIdle);
  end

endmodule

// File: rtl/counter_wait_sum.sv
// NCH lock-stepped counters; once all hold, their total is registered and flagged by done_o.
module counter_wait_sum
  import counter_wait_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NCH   = DefNch,
  localparam int unsigned SW   = WIDTH + $clog2(NCH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 en_i,
  input  logic                 mode_cont_i,
  input  logic [NCH*WIDTH-1:0] stop_val_i,
  output logic [NCH*WIDTH-1:0] cnt_o,
  output logic [NCH-1:0]       hold_mask_o,
  output logic [SW-1:0]        sum_o,
  output logic                 done_o,
  output logic                 busy_o
);

  logic [NCH-1:0] idle_w;
  logic           all_idle;
  logic           all_hold;
  logic           launch;
  logic           fire;
  logic [SW-1:0]  total;
  logic [SW-1:0]  sum_q, sum_d;
  logic           done_q, done_d;

  assign all_idle = &idle_w;
  assign all_hold = &hold_mask_o;
  assign launch   = start_i & en_i & ~abort_i & all_idle;
  assign fire     = all_hold & en_i & ~abort_i;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    cw_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .abort_i (abort_i),
      .launch_i(launch),
      .fire_i  (fire),
      .cont_i  (mode_cont_i),
      .stop_i  (stop_val_i[g*WIDTH +: WIDTH]),
      .cnt_o   (cnt_o[g*WIDTH +: WIDTH]),
      .hold_o  (hold_mask_o[g]),
      .idle_o  (idle_w[g])
    );
  end

  always_comb begin
    total = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      total = total + SW'(cnt_o[i*WIDTH +: WIDTH]);
    end
  end

  // With en low everything freezes, done included; abort always clears done.
  always_comb begin
    sum_d  = sum_q;
    done_d = done_q;
    if (abort_i) begin
      done_d = 1'b0;
    end else if (en_i) begin
      done_d = fire;
      if (fire) sum_d = total;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    sum_o  = sum_q;
    done_o = done_q;
    busy_o = ~all_idle;
  end

endmodule

// File: tb/tb_counter_wait_sum.sv
// Randomised and directed checks of counter_wait_sum against a cycle-level behavioural model.
module tb_counter_wait_sum;

  localparam int W  = 4;
  localparam int N  = 2;
  localparam int SWL = 5;
  localparam int M  = 1 << W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           en = 1'b1;
  logic           mode_cont = 1'b0;
  logic [N*W-1:0] stop_val = '0;
  logic [N*W-1:0] cnt;
  logic [N-1:0]   hold_mask;
  logic [SWL-1:0] sum;
  logic           done;
  logic           busy;

  logic        start3 = 1'b0;
  logic [11:0] stop3 = 12'hfff;
  logic [11:0] cnt3;
  logic [2:0]  hold3;
  logic [5:0]  sum3;
  logic        done3;
  logic        busy3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  counter_wait_sum #(.WIDTH(W), .NCH(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .abort_i    (abort),
    .en_i       (en),
    .mode_cont_i(mode_cont),
    .stop_val_i (stop_val),
    .cnt_o      (cnt),
    .hold_mask_o(hold_mask),
    .sum_o      (sum),
    .done_o     (done),
    .busy_o     (busy)
  );

  counter_wait_sum #(.WIDTH(4), .NCH(3)) dut3 (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start3),
    .abort_i    (1'b0),
    .en_i       (1'b1),
    .mode_cont_i(1'b0),
    .stop_val_i (stop3),
    .cnt_o      (cnt3),
    .hold_mask_o(hold3),
    .sum_o      (sum3),
    .done_o     (done3),
    .busy_o     (busy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a run is "active" from start until the load (one-shot) or abort; each channel counts
  // toward its latched stop, waits, and the group total is published once every channel waits.
  bit m_act;
  int m_cnt[N];
  int m_stop[N];
  bit m_held[N];
  int m_sum;
  bit m_done;

  function automatic bit m_all_held();
    for (int i = 0; i < N; i++) if (!m_held[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_total();
    int t = 0;
    for (int i = 0; i < N; i++) t += m_cnt[i];
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act  <= 1'b0;
      m_sum  <= 0;
      m_done <= 1'b0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i]  <= 0;
        m_stop[i] <= 0;
        m_held[i] <= 1'b0;
      end
    end else if (abort) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
    end else if (en) begin
      if (!m_act) begin
        m_done <= 1'b0;
        if (start) begin
          m_act <= 1'b1;
          for (int i = 0; i < N; i++) begin
            m_cnt[i]  <= 0;
            m_held[i] <= 1'b0;
            m_stop[i] <= int'(stop_val[i*W +: W]);
          end
        end
      end else if (m_all_held()) begin
        m_done <= 1'b1;
        m_sum  <= m_total();
        if (mode_cont) begin
          for (int i = 0; i < N; i++) begin
            m_held[i] <= 1'b0;
            m_cnt[i]  <= (m_cnt[i] + 1) % M;
          end
        end else begin
          m_act <= 1'b0;
        end
      end else begin
        m_done <= 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!m_held[i]) begin
            if (m_cnt[i] == m_stop[i]) m_held[i] <= 1'b1;
            else m_cnt[i] <= (m_cnt[i] + 1) % M;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk($sformatf("cnt%0d", i), 32'(cnt[i*W +: W]), 32'(m_cnt[i]));
      chk($sformatf("hold%0d", i), 32'(hold_mask[i]), 32'(m_act && m_held[i]));
    end
    chk("sum", 32'(sum), 32'(m_sum));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_act));
  end

  // Pulse start for one edge (edge E); returns 2 units after E.
  task automatic do_start(input logic [N*W-1:0] sv);
    @(posedge clk);
    #2;
    stop_val = sv;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  // Counts edges after E until done is seen; en is dropped for edges E+lo+1..E+hi+1.
  task automatic wait_done(input int limit, input int lo, input int hi, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = k;
        break;
      end
      #1;
      en = !(k >= lo && k <= hi);
    end
    en = 1'b1;
  endtask

  int  n, gap, ndone;
  bit  saw15;
  logic [SWL-1:0] sum_before;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_sum", 32'(sum), 0);
    chk("reset_cnt", 32'(cnt), 0);
    #1;
    rst = 1'b0;

    // One-shot stop={2,3}: done 5 edges after E, i.e. cycle 6.
    do_start({4'd3, 4'd2});
    wait_done(30, 0, -1, n);
    chk("oneshot_latency", 32'(n), 5);
    chk("oneshot_sum", 32'(sum), 5);
    chk("oneshot_busy", 32'(busy), 0);

    // Continuous mode: second done 17 cycles later with a 15->0 wrap in between.
    #2;
    mode_cont = 1'b1;
    do_start({4'd3, 4'd2});
    wait_done(30, 0, -1, n);
    chk("cont_first", 32'(n), 5);
    gap = -1;
    saw15 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (cnt[3:0] == 4'd15) saw15 = 1'b1;
      if (done) begin
        gap = k;
        break;
      end
    end
    chk("cont_gap", 32'(gap), 17);
    chk("cont_sum", 32'(sum), 5);
    chk("cont_wrap", 32'(saw15), 1);
    #1;
    mode_cont = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;

    // Abort sampled at the end of cycle 3.
    sum_before = sum;
    do_start({4'd9, 4'd7});
    repeat (2) @(posedge clk);
    #2;
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 0);
    #1;
    abort = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 0);
    chk("abort_sum", 32'(sum), 32'(sum_before));

    // en low during cycles 2-5 pushes done out by exactly 4 cycles.
    do_start({4'd3, 4'd2});
    wait_done(30, 1, 4, n);
    chk("en_gap_latency", 32'(n), 9);
    chk("en_gap_sum", 32'(sum), 5);

    // Three channels at full scale: done in cycle 18 with sum 45.
    @(posedge clk);
    #2;
    start3 = 1'b1;
    @(posedge clk);
    #2;
    start3 = 1'b0;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done3) begin
        n = k;
        break;
      end
    end
    chk("nch3_latency", 32'(n), 17);
    chk("nch3_sum", 32'(sum3), 45);

    // Asynchronous reset while all channels hold, then a fresh run.
    do_start({4'd3, 4'd2});
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(cnt), 0);
    chk("arst_hold", 32'(hold_mask), 0);
    chk("arst_sum", 32'(sum), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_sum3", 32'(sum3), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    do_start({4'd1, 4'd1});
    wait_done(30, 0, -1, n);
    chk("post_rst_latency", 32'(n), 3);
    chk("post_rst_sum", 32'(sum), 2);

    // Random traffic; the per-cycle compare process does the checking.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #2;
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 40) == 0);
      en        = ($urandom_range(0, 7) != 0);
      mode_cont = 1'($urandom_range(0, 1));
      stop_val  = N*W'($urandom);
      if ($urandom_range(0, 500) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
    end
    @(posedge clk);
    #2;
    start = 1'b0;
    abort = 1'b0;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_wait_sum.md
COUNTER_WAIT_SUM -- requirements
Module: counter_wait_sum

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter width in bits (min 2).
REQ-002 Parameter NCH, default 2, SHALL set the channel count (min 1).
REQ-003 Localparam SW SHALL equal WIDTH+$clog2(NCH) and set the sum width.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be asynchronous and active-high.
REQ-006 start  in  1  requests a new run; SHALL be honoured only when busy=0.
REQ-007 abort  in  1  synchronous cancel of the current run.
REQ-008 en  in  1  global advance enable.
REQ-009 mode_cont  in  1  selects mode after a load: 1 = continuous, 0 = one-shot.
REQ-010 stop_val  in  NCH*WIDTH  per-channel stop value; channel i occupies slice [i*WIDTH +: WIDTH].
REQ-011 cnt  out  NCH*WIDTH  per-channel count, using the same slicing.
REQ-012 hold_mask  out  NCH  bit i set while channel i is in HOLD.
REQ-013 sum  out  SW  registered sum of all channel counts.
REQ-014 done  out  1  one-cycle pulse marking a new sum value.
REQ-015 busy  out  1  high while any channel is not IDLE.

Function
REQ-016 Each channel SHALL run a three-state FSM: IDLE, RUN, HOLD.
REQ-017 In IDLE with start=1, abort=0 and en=1: all channels SHALL enter RUN, all counts SHALL clear to 0, and stop_val SHALL be latched; stop_val changes later in the run have no effect.
REQ-018 RUN, en=1, count != latched stop: count SHALL increment modulo 2^WIDTH (wrap 2^WIDTH-1 -> 0); state stays RUN.
REQ-019 RUN, en=1, count == latched stop: state SHALL go to HOLD and the count SHALL hold.
REQ-020 HOLD: the count SHALL hold until all channels are in HOLD.
REQ-021 All channels in HOLD with en=1: sum SHALL load the zero-extended sum of all counts, and done SHALL pulse 1 in the following cycle together with the new sum.
REQ-022 On that same edge with mode_cont=1: all channels SHALL return to RUN, and each count SHALL increment modulo 2^WIDTH.
REQ-023 On that same edge with mode_cont=0: all channels SHALL go to IDLE with counts held.
REQ-024 en=0: no state, count, sum or done change SHALL occur, except for abort and reset.
REQ-025 abort=1: all channels SHALL go to IDLE next cycle, counts and sum hold, and no done is issued; abort SHALL win over start, en and a simultaneous load.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 Latency: with start sampled at edge E, done SHALL be high in the cycle after edge E+max(stop)+2, i.e. max(stop)+3 cycles after the start cycle.
REQ-028 Continuous mode: successive done pulses SHALL be 2^WIDTH+1 cycles apart while en=1.
REQ-029 sum SHALL never overflow; SW covers NCH*(2^WIDTH-1).

Reset
REQ-030 reset=1 SHALL immediately force: all channels IDLE, cnt=0, latched stops=0, sum=0, done=0, hold_mask=0, busy=0.
REQ-031 Reset asserted mid-run SHALL discard the run; after release the block waits for start.

Structure
REQ-032 Shared package counter_wait_pkg SHALL hold the chan_state_t enum (IDLE, RUN, HOLD) and the default WIDTH/NCH constants.
REQ-033 Sub-module cw_channel (one counter, its FSM and its stop latch) SHALL be instantiated NCH times by generate; the top SHALL hold the all-hold detect, adder tree, sum/done registers and mode control.

Verification
REQ-034 WIDTH=4, NCH=2, stop={2,3}, one-shot, start in cycle 0 -> done=1 in cycle 6, sum=5, busy=0 in cycle 6.
REQ-035 Same setup, mode_cont=1 -> second done 17 cycles after the first, sum=5; cnt wraps 15->0 in between.
REQ-036 Start, then abort in cycle 3 -> busy=0 in cycle 4, no done, sum unchanged.
REQ-037 en=0 held for cycles 2-5 of a run with stop={2,3} -> done delayed by exactly 4 cycles, sum=5.
REQ-038 NCH=3, stop={15,15,15} -> sum=45 (SW=6), done in cycle 18.
REQ-039 reset pulsed mid-HOLD, asynchronous to clk -> all outputs 0 immediately; start issued after the reset pulse is processed normally.
